// File: rtl/uart_pkg.sv
// Shared types and constants for the UART block receiver.
// Build option: define UART_RX_PARITY_EN for 8E1 framing with a parity_err output.
package uart_pkg;

    // Bit-level receiver states
    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_RX_PARITY_EN
        PARITY,
`endif
        STOP,
        WAIT_IDLE,
        DONE
    } rx_state_t;

    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;

    localparam int unsigned DIV_W  = 16;
    localparam int unsigned BCNT_W = 6;

    localparam logic [BCNT_W-1:0] LEN_L1  = 6'd48;
    localparam logic [BCNT_W-1:0] LEN_L2  = 6'd32;
    localparam logic [BCNT_W-1:0] LEN_DEF = 6'd16;

    // Bytes per block for a given battery level
    function automatic logic [BCNT_W-1:0] block_len(input logic [2:0] lvl);
        case (lvl)
            3'd1:    block_len = LEN_L1;
            3'd2:    block_len = LEN_L2;
            default: block_len = LEN_DEF;
        endcase
    endfunction

endpackage

// File: rtl/uart_rx_byte.sv
// Byte-level UART receiver: synchroniser, bit-period counter and framing FSM.
// Build option: UART_RX_PARITY_EN adds an even-parity bit before the stop bit.
module uart_rx_byte
    import uart_pkg::*;
#(
    parameter int unsigned CLK_DIV = 5000
) (
    input  logic       Clk,
    input  logic       Rst_n,
    input  logic       i_rx,
    input  logic       i_en,
    input  logic       i_hold,
    input  logic       i_last,
    output logic       o_byte_valid,
    output logic [7:0] o_byte_data,
    output logic       o_frame_err_pulse
`ifdef UART_RX_PARITY_EN
    ,
    output logic       o_parity_err_pulse
`endif
);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(CLK_DIV / 2 - 1);

    rx_state_t        r_state;
    rx_state_t        w_state_nxt;
    logic [1:0]       r_sync;
    logic             r_line_q;
    logic [DIV_W-1:0] r_div_cnt;
    logic [DIV_W-1:0] w_div_nxt;
    logic [2:0]       r_bit_idx;
    logic [2:0]       w_bit_nxt;
    logic [7:0]       r_shift;
    logic [7:0]       w_shift_nxt;
    logic             r_byte_valid;
    logic             w_valid_nxt;
    logic [7:0]       r_byte_data;
    logic [7:0]       w_data_nxt;
    logic             r_ferr;
    logic             w_ferr_nxt;
    logic             w_line;
    logic             w_fall;
    logic             w_bit_end;
`ifdef UART_RX_PARITY_EN
    logic             r_par_bad;
    logic             w_par_bad_nxt;
    logic             r_perr;
    logic             w_perr_nxt;
`endif

    assign w_line    = r_sync[1];
    assign w_fall    = r_line_q & ~w_line;
    assign w_bit_end = (r_div_cnt == DIV_LAST);

    // Synchroniser, FSM state and registered outputs
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_sync       <= 2'b11;
            r_line_q     <= 1'b1;
            r_state      <= IDLE;
            r_div_cnt    <= '0;
            r_bit_idx    <= '0;
            r_shift      <= '0;
            r_byte_valid <= 1'b0;
            r_byte_data  <= '0;
            r_ferr       <= 1'b0;
`ifdef UART_RX_PARITY_EN
            r_par_bad    <= 1'b0;
            r_perr       <= 1'b0;
`endif
        end else begin
            r_sync       <= {r_sync[0], i_rx};
            r_line_q     <= w_line;
            r_state      <= w_state_nxt;
            r_div_cnt    <= w_div_nxt;
            r_bit_idx    <= w_bit_nxt;
            r_shift      <= w_shift_nxt;
            r_byte_valid <= w_valid_nxt;
            r_byte_data  <= w_data_nxt;
            r_ferr       <= w_ferr_nxt;
`ifdef UART_RX_PARITY_EN
            r_par_bad    <= w_par_bad_nxt;
            r_perr       <= w_perr_nxt;
`endif
        end
    end

    // Next-state and output decode; counter restarts on every state change
    always_comb begin
        w_state_nxt   = r_state;
        w_div_nxt     = r_div_cnt + DIV_W'(1);
        w_bit_nxt     = r_bit_idx;
        w_shift_nxt   = r_shift;
        w_valid_nxt   = 1'b0;
        w_data_nxt    = r_byte_data;
        w_ferr_nxt    = 1'b0;
`ifdef UART_RX_PARITY_EN
        w_par_bad_nxt = r_par_bad;
        w_perr_nxt    = 1'b0;
`endif
        if (!i_en) begin
            w_state_nxt = IDLE;
        end else begin
            case (r_state)
                IDLE: begin
                    w_div_nxt = '0;
                    if (w_fall && !i_hold) w_state_nxt = START;
                end
                START: begin
                    if (r_div_cnt == DIV_HALF) begin
                        if (w_line == START_BIT) begin
                            w_state_nxt = DATA;
                            w_bit_nxt   = '0;
                        end else begin
                            w_state_nxt = IDLE;
                        end
                    end
                end
                DATA: begin
                    if (w_bit_end) begin
                        w_div_nxt   = '0;
                        w_shift_nxt = {w_line, r_shift[7:1]};
                        if (r_bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                            w_state_nxt = PARITY;
`else
                            w_state_nxt = STOP;
`endif
                        end else begin
                            w_bit_nxt = r_bit_idx + 3'd1;
                        end
                    end
                end
`ifdef UART_RX_PARITY_EN
                PARITY: begin
                    if (w_bit_end) begin
                        w_par_bad_nxt = (^r_shift) ^ w_line;
                        w_state_nxt   = STOP;
                    end
                end
`endif
                STOP: begin
                    if (w_bit_end) begin
                        if (w_line == STOP_BIT) begin
`ifdef UART_RX_PARITY_EN
                            if (r_par_bad) begin
                                w_perr_nxt  = 1'b1;
                                w_state_nxt = IDLE;
                            end else begin
                                w_valid_nxt = 1'b1;
                                w_data_nxt  = r_shift;
                                w_state_nxt = i_last ? DONE : IDLE;
                            end
`else
                            w_valid_nxt = 1'b1;
                            w_data_nxt  = r_shift;
                            w_state_nxt = i_last ? DONE : IDLE;
`endif
                        end else begin
                            w_ferr_nxt  = 1'b1;
                            w_state_nxt = WAIT_IDLE;
                        end
                    end
                end
                WAIT_IDLE: begin
                    if (!w_line) begin
                        w_div_nxt = '0;
                    end else if (w_bit_end) begin
                        w_state_nxt = IDLE;
                    end
                end
                DONE: begin
                    w_div_nxt = '0;
                end
                default: begin
                    w_state_nxt = IDLE;
                end
            endcase
        end
        if (w_state_nxt != r_state) w_div_nxt = '0;
    end

    assign o_byte_valid      = r_byte_valid;
    assign o_byte_data       = r_byte_data;
    assign o_frame_err_pulse = r_ferr;
`ifdef UART_RX_PARITY_EN
    assign o_parity_err_pulse = r_perr;
`endif

endmodule

// File: rtl/uart_rx_block.sv
// UART block receiver: packs received bytes into a plaintext block for the cipher core.
// Build option: UART_RX_PARITY_EN selects 8E1 framing and adds the parity_err output.
module uart_rx_block
    import uart_pkg::*;
#(
    parameter int unsigned CLK_DIV    = 5000,
    parameter int unsigned BLOCK_BITS = 384
) (
    input  logic                  Clk,
    input  logic                  Rst_n,
    input  logic                  Rs232_Rx,
    input  logic                  rx_en,
    input  logic [2:0]            Battery_level,
    output logic [BLOCK_BITS-1:0] plain_text,
    output logic                  rx_done,
    output logic                  frame_err,
    output logic [BCNT_W-1:0]     byte_cnt
`ifdef UART_RX_PARITY_EN
    ,
    output logic                  parity_err
`endif
);

    localparam int unsigned NBYTES = BLOCK_BITS / 8;

    logic                  r_en_q;
    logic [BCNT_W-1:0]     r_target;
    logic [BLOCK_BITS-1:0] r_plain;
    logic                  r_done;
    logic                  r_ferr;
    logic [BCNT_W-1:0]     r_cnt;
    logic                  w_en_rise;
    logic                  w_last;
    logic                  w_byte_valid;
    logic [7:0]            w_byte_data;
    logic                  w_frame_err_pulse;
`ifdef UART_RX_PARITY_EN
    logic                  r_perr;
    logic                  w_parity_err_pulse;
`endif

    assign w_en_rise = rx_en & ~r_en_q;
    assign w_last    = ((r_cnt + BCNT_W'(1)) == r_target);

    uart_rx_byte #(
        .CLK_DIV (CLK_DIV)
    ) u_rx_byte (
        .Clk                (Clk),
        .Rst_n              (Rst_n),
        .i_rx               (Rs232_Rx),
        .i_en               (rx_en),
        .i_hold             (r_done),
        .i_last             (w_last),
        .o_byte_valid       (w_byte_valid),
        .o_byte_data        (w_byte_data),
        .o_frame_err_pulse  (w_frame_err_pulse)
`ifdef UART_RX_PARITY_EN
        ,
        .o_parity_err_pulse (w_parity_err_pulse)
`endif
    );

    // Block packing, length latch and enable/done handling
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_en_q   <= 1'b0;
            r_target <= LEN_DEF;
            r_plain  <= '0;
            r_done   <= 1'b0;
            r_ferr   <= 1'b0;
            r_cnt    <= '0;
`ifdef UART_RX_PARITY_EN
            r_perr   <= 1'b0;
`endif
        end else begin
            r_en_q <= rx_en;
            if (w_en_rise) begin
                r_target <= block_len(Battery_level);
                r_plain  <= '0;
            end
            if (!rx_en) begin
                r_done <= 1'b0;
                r_ferr <= 1'b0;
                r_cnt  <= '0;
`ifdef UART_RX_PARITY_EN
                r_perr <= 1'b0;
`endif
            end else begin
                if (w_frame_err_pulse) r_ferr <= 1'b1;
`ifdef UART_RX_PARITY_EN
                if (w_parity_err_pulse) r_perr <= 1'b1;
`endif
                if (w_byte_valid && !r_done) begin
                    for (int k = 0; k < NBYTES; k++) begin
                        if (r_cnt == BCNT_W'(k)) r_plain[8*k +: 8] <= w_byte_data;
                    end
                    r_cnt <= r_cnt + BCNT_W'(1);
                    if (w_last) r_done <= 1'b1;
                end
            end
        end
    end

    assign plain_text = r_plain;
    assign rx_done    = r_done;
    assign frame_err  = r_ferr;
    assign byte_cnt   = r_cnt;
`ifdef UART_RX_PARITY_EN
    assign parity_err = r_perr;
`endif

endmodule

// File: tb/tb_uart_rx_block.sv
// Directed self-checking bench for uart_rx_block with CLK_DIV = 16.
module tb_uart_rx_block;

    localparam int unsigned CLK_DIV = 16;
    localparam int unsigned BB      = 384;

    logic          Clk = 1'b0;
    logic          Rst_n;
    logic          Rs232_Rx;
    logic          rx_en;
    logic [2:0]    Battery_level;
    logic [BB-1:0] plain_text;
    logic          rx_done;
    logic          frame_err;
    logic [5:0]    byte_cnt;
`ifdef UART_RX_PARITY_EN
    logic          parity_err;
`endif

    int            n_cmp = 0;
    int            n_bad = 0;
    logic [BB-1:0] exp_pt;

    always #5 Clk = ~Clk;

    uart_rx_block #(
        .CLK_DIV    (CLK_DIV),
        .BLOCK_BITS (BB)
    ) dut (
        .Clk           (Clk),
        .Rst_n         (Rst_n),
        .Rs232_Rx      (Rs232_Rx),
        .rx_en         (rx_en),
        .Battery_level (Battery_level),
        .plain_text    (plain_text),
        .rx_done       (rx_done),
        .frame_err     (frame_err),
        .byte_cnt      (byte_cnt)
`ifdef UART_RX_PARITY_EN
        ,
        .parity_err    (parity_err)
`endif
    );

    task automatic check_eq(input string tag, input logic [BB-1:0] obs, input logic [BB-1:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic line_bit(input logic v);
        Rs232_Rx = v;
        repeat (CLK_DIV) @(negedge Clk);
    endtask

    // One frame; with lat set, rx_done is checked around the stop-bit sample
    task automatic send_byte(input logic [7:0] d, input logic stop_v, input bit lat);
        line_bit(1'b0);
        for (int i = 0; i < 8; i++) line_bit(d[i]);
`ifdef UART_RX_PARITY_EN
        line_bit(^d);
`endif
        if (lat) begin
            Rs232_Rx = stop_v;
            repeat (11) @(negedge Clk);
            check_eq("done_before_lat", BB'(rx_done), BB'(1'b0));
            @(negedge Clk);
            check_eq("done_at_lat", BB'(rx_done), BB'(1'b1));
            repeat (4) @(negedge Clk);
        end else begin
            line_bit(stop_v);
        end
        Rs232_Rx = 1'b1;
        repeat (2) @(negedge Clk);
    endtask

    initial begin
        #(200000 * 10);
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        Rst_n         = 1'b0;
        Rs232_Rx      = 1'b1;
        rx_en         = 1'b0;
        Battery_level = 3'd3;
        repeat (3) @(negedge Clk);
        check_eq("rst_plain", plain_text, '0);
        check_eq("rst_done", BB'(rx_done), BB'(1'b0));
        check_eq("rst_ferr", BB'(frame_err), BB'(1'b0));
        check_eq("rst_cnt", BB'(byte_cnt), BB'(6'd0));
        Rst_n = 1'b1;
        repeat (3) @(negedge Clk);

        // 16-byte block, 0x00..0x0F
        rx_en = 1'b1;
        repeat (3) @(negedge Clk);
        exp_pt = '0;
        for (int k = 0; k < 16; k++) begin
            exp_pt[8*k +: 8] = 8'(k);
            send_byte(8'(k), 1'b1, k == 15);
        end
        check_eq("b16_plain", plain_text, exp_pt);
        check_eq("b16_cnt", BB'(byte_cnt), BB'(6'd16));
        check_eq("b16_ferr", BB'(frame_err), BB'(1'b0));

        // Disable keeps plaintext, clears status
        rx_en = 1'b0;
        repeat (2) @(negedge Clk);
        check_eq("dis_done", BB'(rx_done), BB'(1'b0));
        check_eq("dis_cnt", BB'(byte_cnt), BB'(6'd0));
        check_eq("dis_plain", plain_text, exp_pt);

        // 48-byte block of 0xA5, then an ignored 49th byte
        Battery_level = 3'd1;
        rx_en = 1'b1;
        @(negedge Clk);
        check_eq("en_clear_plain", plain_text, '0);
        for (int k = 0; k < 47; k++) send_byte(8'hA5, 1'b1, 1'b0);
        check_eq("b48_done_early", BB'(rx_done), BB'(1'b0));
        check_eq("b48_cnt_47", BB'(byte_cnt), BB'(6'd47));
        send_byte(8'hA5, 1'b1, 1'b1);
        exp_pt = {48{8'hA5}};
        check_eq("b48_plain", plain_text, exp_pt);
        check_eq("b48_cnt", BB'(byte_cnt), BB'(6'd48));
        send_byte(8'h3C, 1'b1, 1'b0);
        check_eq("b49_plain", plain_text, exp_pt);
        check_eq("b49_cnt", BB'(byte_cnt), BB'(6'd48));
        check_eq("b49_done", BB'(rx_done), BB'(1'b1));

        // Start-bit glitch of 3 cycles on a 32-byte block
        rx_en = 1'b0;
        repeat (2) @(negedge Clk);
        Battery_level = 3'd2;
        rx_en = 1'b1;
        repeat (2) @(negedge Clk);
        Rs232_Rx = 1'b0;
        repeat (3) @(negedge Clk);
        Rs232_Rx = 1'b1;
        repeat (40) @(negedge Clk);
        check_eq("glitch_cnt", BB'(byte_cnt), BB'(6'd0));
        check_eq("glitch_ferr", BB'(frame_err), BB'(1'b0));
        check_eq("glitch_plain", plain_text, '0);

        // Stop bit forced low, then recovery after idle line
        send_byte(8'h3C, 1'b0, 1'b0);
        check_eq("ferr_set", BB'(frame_err), BB'(1'b1));
        check_eq("ferr_cnt", BB'(byte_cnt), BB'(6'd0));
        repeat (CLK_DIV) @(negedge Clk);
        send_byte(8'h55, 1'b1, 1'b0);
        check_eq("recover_plain", plain_text, BB'(8'h55));
        check_eq("recover_cnt", BB'(byte_cnt), BB'(6'd1));
        check_eq("ferr_sticky", BB'(frame_err), BB'(1'b1));

        // Abort after 5 of 32 bytes
        for (int k = 0; k < 4; k++) send_byte(8'(8'h11 + k), 1'b1, 1'b0);
        check_eq("abort_cnt5", BB'(byte_cnt), BB'(6'd5));
        rx_en = 1'b0;
        repeat (2) @(negedge Clk);
        rx_en = 1'b1;
        @(negedge Clk);
        check_eq("abort_cnt0", BB'(byte_cnt), BB'(6'd0));
        check_eq("abort_plain", plain_text, '0);
        check_eq("abort_ferr", BB'(frame_err), BB'(1'b0));
        send_byte(8'h9A, 1'b1, 1'b0);
        check_eq("abort_next", plain_text, BB'(8'h9A));
        check_eq("abort_next_cnt", BB'(byte_cnt), BB'(6'd1));

        // Reset in the middle of the data bits
        line_bit(1'b0);
        line_bit(1'b1);
        line_bit(1'b0);
        Rst_n = 1'b0;
        #1;
        check_eq("mid_rst_plain", plain_text, '0);
        check_eq("mid_rst_cnt", BB'(byte_cnt), BB'(6'd0));
        check_eq("mid_rst_done", BB'(rx_done), BB'(1'b0));
        check_eq("mid_rst_ferr", BB'(frame_err), BB'(1'b0));
        Rs232_Rx = 1'b1;
        repeat (4) @(negedge Clk);
        Rst_n = 1'b1;
        repeat (4) @(negedge Clk);
        send_byte(8'hC3, 1'b1, 1'b0);
        check_eq("post_rst_plain", plain_text, BB'(8'hC3));
        check_eq("post_rst_cnt", BB'(byte_cnt), BB'(6'd1));
`ifdef UART_RX_PARITY_EN
        check_eq("parity_clean", BB'(parity_err), BB'(1'b0));
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/uart_rx_block.md
Name: uart_rx_block

Overview:
- Serial receiver for the 8N1 link driven by the board's block transmitter.
- Deserialises LSB-first bytes from Rs232_Rx and packs them into a 384-bit plaintext block buffer.
- The number of bytes per block is selected by Battery_level: 48, 32 or 16 bytes.
- Signals block completion to the cipher core, which consumes plain_text.

Parameters:
- CLK_DIV, 5000, Clk cycles per bit; must be ≥ 4 and ≤ 65535.
- BLOCK_BITS, 384, buffer width; must be a multiple of 8.

Ports:
- Clk  in  1  system clock
- Rst_n  in  1  reset, asynchronous, active-low
- Rs232_Rx  in  1  serial line, idle high, asynchronous to Clk
- rx_en  in  1  level enable; low aborts the current block and clears counters
- Battery_level  in  3  block length select: 1 -> 48 bytes, 2 -> 32 bytes, other values -> 16 bytes
- plain_text  out  BLOCK_BITS  received block; byte k occupies bits [8k+7:8k]
- rx_done  out  1  high from block completion until rx_en goes low
- frame_err  out  1  sticky; set on a stop bit sampled low, cleared by rx_en low
- byte_cnt  out  6  bytes stored in the current block

Behaviour:
- Reset values: plain_text = 0, rx_done = 0, frame_err = 0, byte_cnt = 0, FSM = IDLE, synchroniser flops = 1.
- Input path: Rs232_Rx passes through a 2-flop synchroniser. All references to the line below mean the synchronised value.
- Block length target:
  - Latched on the rx_en 0->1 edge as 48, 32 or 16 bytes.
  - Battery_level changes mid-block are ignored.
- On the rx_en 0->1 edge, plain_text is cleared to 0 in the same cycle.
- Bit-period counter div_cnt (16 bit): reloads to 0 on every FSM state entry; compare values are CLK_DIV-1 and CLK_DIV/2-1.
- FSM states and transitions:
  - IDLE: enter START on a 1->0 line edge, only when rx_en=1 and rx_done=0.
  - START: at div_cnt = CLK_DIV/2-1, sample the line.
    - 0 -> enter DATA with bit_idx = 0.
    - 1 -> glitch; return to IDLE with no state change.
  - DATA: every CLK_DIV cycles, sample at mid-bit and shift into a shift register, LSB first. After the 8th sample, enter STOP.
  - STOP: sample after CLK_DIV cycles.
    - 1 -> write the byte to plain_text[8*byte_cnt +: 8] and increment byte_cnt. If the new byte_cnt equals the target, set rx_done and go to DONE; otherwise go to IDLE.
    - 0 -> set frame_err, discard the byte, go to WAIT_IDLE.
  - WAIT_IDLE: stay until the line has been 1 for CLK_DIV consecutive cycles, then go to IDLE.
  - DONE: hold plain_text, byte_cnt and rx_done until rx_en = 0.
- rx_en = 0 in any state: next cycle FSM = IDLE, rx_done = 0, frame_err = 0, byte_cnt = 0. plain_text is retained.
- Reset mid-frame: all state returns to reset values immediately.
- Latency: the last byte becomes visible in plain_text, and rx_done rises, on the same Clk edge, one cycle after the stop-bit sample.
- Bytes arriving in DONE are ignored; no overrun flag.

Optional Feature:
- UART_RX_PARITY_EN
  - Defined: frame is 8E1. An even-parity bit is sampled between data and stop, and an extra output parity_err (1 bit, sticky, cleared by rx_en low) is added. On parity mismatch, parity_err is set, the byte is discarded, and byte_cnt does not advance. A stop-bit error still takes precedence via WAIT_IDLE.
  - Undefined: 8N1 framing; no parity_err port.

Decomposition:
- Shared package uart_pkg:
  - State enum (IDLE, START, DATA, STOP, WAIT_IDLE, DONE, plus PARITY when enabled).
  - START_BIT = 0, STOP_BIT = 1.
  - Length constants LEN_L1 = 48, LEN_L2 = 32, LEN_DEF = 16.
- Sub-module uart_rx_byte: synchroniser, bit-period counter and bit-level FSM, outputting byte_valid, byte_data and frame_err_pulse.
- The top level does block packing, length select and done/enable handling.

Test Plan:
- CLK_DIV = 16, Battery_level = 3, rx_en rises, send 16 bytes 0x00..0x0F:
  - plain_text[127:0] = 0x0F0E…0100 and upper bits 0.
  - rx_done rises one cycle after the last stop sample; byte_cnt = 16.
- Battery_level = 1, send 48 bytes 0xA5:
  - rx_done only after the 48th byte; plain_text = {48{8'hA5}}.
  - A 49th byte sent while rx_done is high leaves plain_text unchanged.
- 0-pulse of 3 cycles (< CLK_DIV/2) on the idle line: no byte stored, byte_cnt unchanged, frame_err = 0.
- Byte 0x3C sent with the stop bit forced 0:
  - frame_err = 1, byte_cnt unchanged.
  - Line idle for 16 cycles, then byte 0x55 is stored at byte index 0.
- rx_en dropped after 5 of 32 bytes, then raised: byte_cnt = 0, plain_text cleared, next byte lands in bits [7:0].
- Rst_n asserted mid-DATA: all outputs at reset values immediately; a byte sent after release is received correctly.
